mmio_regfile: RTL and testbench



---
 rtl/mmio_regfile.sv | 107 ++++++++++
 tb/tb_mmio_regfile.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_regfile.sv
// Memory-mapped bank of WORDS 32-bit registers with byte strobes, per-bit write
// masks, write-1-to-clear bits, hardware set inputs, registered reads and write notifies.
module mmio_regfile #(
   parameter int unsigned         WORDS       = 4,
   parameter logic [32*WORDS-1:0] RESET_VALUE = '0,
   parameter logic [32*WORDS-1:0] WMASK       = '1,
   parameter logic [32*WORDS-1:0] W1C_MASK    = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  re,
   input  logic                  we,
   input  logic [3:0]            wstrb,
   input  logic [31:0]           wd,
   input  logic [29:0]           addr,
   output logic [31:0]           rd,
   output logic                  rvalid,
   output logic                  err,
   output logic [32*WORDS-1:0]   hw_rd,
   input  logic [32*WORDS-1:0]   hw_set,
   output logic [WORDS-1:0]      wr_pulse
);

   localparam int unsigned SW = (WORDS > 1) ? $clog2(WORDS) : 1;

   logic [WORDS-1:0][31:0] regs_q, regs_d;
   logic [31:0]            rd_q, rd_d;
   logic                   rvalid_q, rvalid_d;
   logic                   err_q, err_d;
   logic [WORDS-1:0]       wr_pulse_q, wr_pulse_d;

   logic [SW:0]            sel_ext;
   logic                   in_range;
   logic [31:0]            byte_en;
   logic [31:0]            rd_word;
   logic                   unused_addr;

   assign sel_ext     = {1'b0, addr[SW-1:0]};
   assign in_range    = (sel_ext < (SW+1)'(WORDS));
   assign unused_addr = ^addr[29:SW];
   assign byte_en     = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};

   // Software view of one word: masked bits either take wd or clear where wd is 1.
   function automatic logic [31:0] sw_write(input logic [31:0] old_val,
                                            input logic [31:0] data,
                                            input logic [31:0] wmask,
                                            input logic [31:0] w1c);
      logic [31:0] plain_bits;
      logic [31:0] clear_bits;
      plain_bits = wmask & ~w1c & data;
      clear_bits = wmask &  w1c & old_val & ~data;
      return (old_val & ~wmask) | plain_bits | clear_bits;
   endfunction

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      regs_d     = regs_q;
      rd_d       = rd_q;
      rvalid_d   = re;
      err_d      = (re || we) && !in_range;
      wr_pulse_d = '0;
      rd_word    = '0;

      for (int i = 0; i < int'(WORDS); i++) begin
         if (sel_ext == (SW+1)'(i)) begin
            rd_word = regs_q[i];
            if (we && (wstrb != 4'b0000)) begin
               regs_d[i]     = sw_write(regs_q[i], wd,
                                        WMASK[32*i +: 32] & byte_en,
                                        W1C_MASK[32*i +: 32]);
               wr_pulse_d[i] = 1'b1;
            end
         end
         // Hardware set is applied last so it beats a same-cycle clear or write-0.
         regs_d[i] = regs_d[i] | hw_set[32*i +: 32];
      end

      if (re) begin
         rd_d = in_range ? rd_word : 32'h0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the bank is plain flops, so it resets to the parameter image like any other state.
         regs_q     <= RESET_VALUE;
         rd_q       <= '0;
         rvalid_q   <= 1'b0;
         err_q      <= 1'b0;
         wr_pulse_q <= '0;
      end else begin
         // NOTE: non-blocking updates keep every flop sampling pre-edge values.
         regs_q     <= regs_d;
         rd_q       <= rd_d;
         rvalid_q   <= rvalid_d;
         err_q      <= err_d;
         wr_pulse_q <= wr_pulse_d;
      end
   end

   assign hw_rd    = regs_q;
   assign rd       = rd_q;
   assign rvalid   = rvalid_q;
   assign err      = err_q;
   assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_mmio_regfile.sv
// Self-checking bench for mmio_regfile: a 4-word instance with a read scoreboard
// and a 3-word instance for out-of-range decode and reset-during-read.
module tb_mmio_regfile;

   localparam logic [127:0] RV4  = {32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000};
   localparam logic [127:0] WM4  = {32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   localparam logic [127:0] W1C4 = {32'h0000_000F, 96'h0};

   logic         clk = 1'b0;
   logic         rst;

   logic         re, we;
   logic [3:0]   wstrb;
   logic [31:0]  wd;
   logic [29:0]  addr;
   logic [31:0]  rd;
   logic         rvalid, err;
   logic [127:0] hw_rd, hw_set;
   logic [3:0]   wr_pulse;

   logic         re3, we3;
   logic [3:0]   wstrb3;
   logic [31:0]  wd3;
   logic [29:0]  addr3;
   logic [31:0]  rd3;
   logic         rvalid3, err3;
   logic [95:0]  hw_rd3, hw_set3;
   logic [2:0]   wr_pulse3;

   typedef struct packed {
      logic [31:0] rd;
      logic        err;
   } rsp_t;

   rsp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mmio_regfile #(.WORDS(4), .RESET_VALUE(RV4), .WMASK(WM4), .W1C_MASK(W1C4)) u_dut (
      .clk(clk), .rst(rst), .re(re), .we(we), .wstrb(wstrb), .wd(wd), .addr(addr),
      .rd(rd), .rvalid(rvalid), .err(err), .hw_rd(hw_rd), .hw_set(hw_set),
      .wr_pulse(wr_pulse));

   mmio_regfile #(.WORDS(3)) u_dut3 (
      .clk(clk), .rst(rst), .re(re3), .we(we3), .wstrb(wstrb3), .wd(wd3), .addr(addr3),
      .rd(rd3), .rvalid(rvalid3), .err(err3), .hw_rd(hw_rd3), .hw_set(hw_set3),
      .wr_pulse(wr_pulse3));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Read responses are matched in order against what the stimulus predicted.
   always @(negedge clk) begin
      if (!rst && rvalid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_rvalid", 32'd1, 32'd0);
         end else begin
            rsp_t exp_rsp;
            exp_rsp = sb_q.pop_front();
            check("sb_rd", rd, exp_rsp.rd);
            check("sb_err", {31'd0, err}, {31'd0, exp_rsp.err});
         end
      end
   end

   task automatic op(input logic r, input logic w, input logic [29:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] exp_rd, input logic exp_err);
      re = r; we = w; addr = a; wd = d; wstrb = s;
      if (r) sb_q.push_back('{rd: exp_rd, err: exp_err});
      @(negedge clk);
   endtask

   task automatic idle();
      re = 1'b0; we = 1'b0; wstrb = 4'h0;
      re3 = 1'b0; we3 = 1'b0; wstrb3 = 4'h0;
      @(negedge clk);
   endtask

   task automatic op3(input logic r, input logic w, input logic [29:0] a,
                      input logic [31:0] d, input logic [3:0] s);
      re3 = r; we3 = w; addr3 = a; wd3 = d; wstrb3 = s;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      re = 0; we = 0; wstrb = 0; wd = 0; addr = 0; hw_set = '0;
      re3 = 0; we3 = 0; wstrb3 = 0; wd3 = 0; addr3 = 0; hw_set3 = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("rst_rd", rd, 32'h0);
      check("rst_rvalid", {31'd0, rvalid}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_wr_pulse", {28'd0, wr_pulse}, 32'd0);
      check("rst_word1", hw_rd[63:32], 32'hDEAD_BEEF);
      check("rst_word2", hw_rd[95:64], 32'h0);

      // Reset image readback
      op(1, 0, 30'd1, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
      idle();

      // Byte strobes
      op(0, 1, 30'd0, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
      check("strb_pulse", {28'd0, wr_pulse}, 32'h1);
      check("strb_err", {31'd0, err}, 32'd0);
      check("strb_word0", hw_rd[31:0], 32'h0022_0044);
      idle();
      check("strb_pulse_drop", {28'd0, wr_pulse}, 32'h0);

      // Read-only bits
      op(0, 1, 30'd2, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0);
      check("wmask_word2", hw_rd[95:64], 32'h0000_00FF);
      check("wmask_pulse", {28'd0, wr_pulse}, 32'h4);
      idle();

      // Zero strobes: no change, no pulse
      op(0, 1, 30'd0, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
      check("nostrb_pulse", {28'd0, wr_pulse}, 32'h0);
      check("nostrb_word0", hw_rd[31:0], 32'h0022_0044);
      idle();

      // Hardware set and write-1-to-clear
      hw_set[99:96] = 4'hF;
      @(negedge clk);
      hw_set = '0;
      check("hwset_word3", hw_rd[127:96], 32'h0000_000F);
      hw_set[96] = 1'b1;
      op(0, 1, 30'd3, 32'h0000_0005, 4'hF, 32'h0, 1'b0);
      hw_set = '0;
      check("w1c_hw_prio", hw_rd[127:96], 32'h0000_000B);
      op(0, 1, 30'd3, 32'h0000_0001, 4'hF, 32'h0, 1'b0);
      check("w1c_clear0", hw_rd[127:96], 32'h0000_000A);
      idle();

      // Read-before-write, back-to-back reads, ignored upper address bits
      op(0, 1, 30'd1, 32'h0000_000A, 4'hF, 32'h0, 1'b0);
      op(1, 1, 30'd1, 32'h0000_000B, 4'hF, 32'h0000_000A, 1'b0);
      op(1, 0, 30'd1, 32'h0, 4'h0, 32'h0000_000B, 1'b0);
      op(1, 0, 30'h3FFF_FFFC, 32'h0, 4'h0, 32'h0022_0044, 1'b0);
      op(1, 0, 30'd3, 32'h0, 4'h0, 32'h0000_000A, 1'b0);
      idle();
      check("rd_hold_rvalid", {31'd0, rvalid}, 32'd0);
      check("rd_hold_value", rd, 32'h0000_000A);
      check("sb_empty", sb_q.size(), 32'd0);

      // Non-power-of-two bank: word address 3 is out of range
      op3(0, 1, 30'd0, 32'h5555_AAAA, 4'hF);
      check("w3_pulse", {29'd0, wr_pulse3}, 32'h1);
      op3(1, 0, 30'd0, 32'h0, 4'h0);
      check("w3_rd0", rd3, 32'h5555_AAAA);
      check("w3_rd0_err", {31'd0, err3}, 32'd0);
      op3(1, 0, 30'd3, 32'h0, 4'h0);
      check("oor_rd", rd3, 32'h0);
      check("oor_rd_rvalid", {31'd0, rvalid3}, 32'd1);
      check("oor_rd_err", {31'd0, err3}, 32'd1);
      op3(0, 1, 30'd3, 32'hFFFF_FFFF, 4'hF);
      check("oor_wr_err", {31'd0, err3}, 32'd1);
      check("oor_wr_rvalid", {31'd0, rvalid3}, 32'd0);
      check("oor_wr_pulse", {29'd0, wr_pulse3}, 32'h0);
      check("oor_wr_w0", hw_rd3[31:0], 32'h5555_AAAA);
      check("oor_wr_w1", hw_rd3[63:32], 32'h0);
      check("oor_wr_w2", hw_rd3[95:64], 32'h0);
      op3(1, 1, 30'd3, 32'hFFFF_FFFF, 4'hF);
      check("oor_both_err", {31'd0, err3}, 32'd1);
      idle();
      check("oor_err_single", {31'd0, err3}, 32'd0);

      // Reset between a read request and its response
      re3 = 1'b1; addr3 = 30'd0;
      #2 rst = 1'b1;
      @(negedge clk);
      re3 = 1'b0;
      check("rst_mid_rvalid", {31'd0, rvalid3}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_rvalid2", {31'd0, rvalid3}, 32'd0);
      check("rst_mid_w0", hw_rd3[31:0], 32'h0);
      check("rst_mid_dut4_w1", hw_rd[63:32], 32'hDEAD_BEEF);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
